// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice: streams latched operands
// LSB-first, chains the slice carry, and assembles the WIDTH-bit result.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             alu_opA,
  output logic             alu_opB,
  output logic [3:0]       alu_S,
  output logic             alu_M,
  output logic             alu_Cin,
  input  logic             alu_DO,
  input  logic             alu_CO
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       s_q;
  logic             m_q, cin_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last_c;

  assign last_c = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry chain, result assembly and registered status outputs.
  // In logic mode the carry register is reloaded with the latched cin every bit,
  // so alu_Cin is always a plain register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            cin_q   <= cin;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          result  <= {alu_DO, result[WIDTH-1:1]};
          carry_q <= m_q ? cin_q : alu_CO;
          cnt_q   <= cnt_q + CW'(1);
          if (last_c) begin
            done <= 1'b1;
            cout <= m_q ? 1'b0 : alu_CO;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_opA = a_q[0];
  assign alu_opB = b_q[0];
  assign alu_S   = s_q;
  assign alu_M   = m_q;
  assign alu_Cin = carry_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a full-adder stub standing in for the ALU slice.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [3:0]   s;
  logic         m, cin;
  logic         busy, done, cout;
  logic [W-1:0] result;
  logic         alu_opA, alu_opB, alu_M, alu_Cin, alu_DO, alu_CO;
  logic [3:0]   alu_S;

  int n_cmp = 0;
  int n_err = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S), .alu_M(alu_M),
    .alu_Cin(alu_Cin), .alu_DO(alu_DO), .alu_CO(alu_CO)
  );

  // Stub ALU slice: full adder
  assign alu_DO = alu_opA ^ alu_opB ^ alu_Cin;
  assign alu_CO = (alu_opA & alu_opB) | (alu_opA & alu_Cin) | (alu_opB & alu_Cin);

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  int         busy_cnt;
  bit         ctl_bad, cin_bad;
  logic [3:0] exp_s;
  logic       exp_m, exp_cin;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Whole-word reference: add with carry-in, or bitwise xor with a constant carry
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mm, input logic mc);
    if (!mm) return (W+1)'(ma) + (W+1)'(mb) + (W+1)'(mc);
    return {1'b0, ma ^ mb ^ {W{mc}}};
  endfunction

  // Called at the negedge right after start was accepted; bounded wait for done
  task automatic wait_done(output bit seen);
    busy_cnt = 0; ctl_bad = 0; cin_bad = 0; seen = 0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) begin
          busy_cnt++;
          if (alu_S !== exp_s || alu_M !== exp_m) ctl_bad = 1;
          if (exp_m && alu_Cin !== exp_cin) cin_bad = 1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] ts,
                       input logic tm, input logic tc, input logic [W-1:0] er, input logic ec,
                       input string name);
    bit seen;
    a = ta; b = tb; s = ts; m = tm; cin = tc; start = 1'b1;
    exp_s = ts; exp_m = tm; exp_cin = tc;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({name, "_result"}, 32'(result), 32'(er));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_ctl_stable"}, 32'(ctl_bad), 32'd0);
    if (tm) check({name, "_cin_fixed"}, 32'(cin_bad), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;
    int t, t1, t2;
    logic [W-1:0] r1;
    logic [W:0]   ref_v;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_alu", 32'({alu_opA, alu_opB, alu_S, alu_M, alu_Cin}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{8'h3C, 8'h0F, 4'h9, 1'b0, 1'b0, 8'h4B, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 4'h9, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 4'h9, 1'b0, 1'b1, 8'h01, 1'b0});
    vecs.push_back('{8'hA5, 8'h0F, 4'h6, 1'b1, 1'b0, 8'hAA, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 4'h9, 1'b0, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 4'h9, 1'b0, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'hF0, 8'hCC, 4'h3, 1'b1, 1'b1, 8'hC3, 1'b0});
    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin,
            vecs[i].exp_res, vecs[i].exp_cout, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rs;
      logic         rm, rc;
      ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom);
      rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      ref_v = model(ra, rb, rm, rc);
      do_op(ra, rb, rs, rm, rc, ref_v[W-1:0], ref_v[W], $sformatf("rnd%0d", i));
    end

    // Start pulses with new operands during RUN are ignored and not queued
    a = 8'h3C; b = 8'h0F; s = 4'h9; m = 1'b0; cin = 1'b0; start = 1'b1;
    exp_s = 4'h9; exp_m = 1'b0; exp_cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    a = 8'hFF; b = 8'hFF; s = 4'h2; m = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    check("ign_done_seen", 32'(seen), 32'd1);
    check("ign_result", 32'(result), 32'h4B);
    check("ign_cout", 32'(cout), 32'd0);
    check("ign_ctl_stable", 32'(ctl_bad), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("ign_no_queue", 32'(seen), 32'd0);

    // Start held high: second op accepted right after DONE, period WIDTH+2
    a = 8'h3C; b = 8'h0F; s = 4'h9; m = 1'b0; cin = 1'b0; start = 1'b1;
    t = 0; t1 = -1; t2 = -1; r1 = '0;
    for (int i = 0; i < 6 * W && t2 < 0; i++) begin
      @(negedge clk);
      t++;
      if (done) begin
        if (t1 < 0) begin t1 = t; r1 = result; end
        else begin t2 = t; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("b2b_first_result", 32'(r1), 32'h4B);
    check("b2b_second_result", 32'(result), 32'h4B);
    check("b2b_period", 32'(t2 - t1), 32'(W + 2));
    @(negedge clk); @(negedge clk);

    // Asynchronous reset at bit 4 aborts the operation
    a = 8'hFF; b = 8'hFF; s = 4'hA; m = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_alu", 32'({alu_opA, alu_opB, alu_S, alu_M, alu_Cin}), 32'd0);
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h01, 8'h01, 4'h9, 1'b0, 1'b0, 8'h02, 1'b0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
